sram_responder: RTL and testbench

- Memory-side responder for the CPU's SRAM-like interface: accepts en/wen/addr/wdata requests and returns read data after a fixed latency.
- Instantiated once for instruction SRAM and once for data SRAM in simulation and FPGA top-levels.
- Performs kseg0/kseg1 virtual-to-physical mapping, byte-lane writes, range checking with a sticky error report, and a configurable read pipeline.

---
 rtl/sram_responder.sv | 114 +++++++++++
 tb/tb_sram_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - SRAM-like memory responder with kseg mapping, range check and read pipeline
// Optional access counters are enabled by defining SRAM_ACCESS_CNT_EN.
module sram_responder #(
  parameter int          ADDR_BITS  = 16,
  parameter logic [31:0] BASE_PADDR = 32'h1FC00000,
  parameter int          READ_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        rdata_valid,
  output logic        addr_err,
  output logic [31:0] err_addr
`ifdef SRAM_ACCESS_CNT_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int DEPTH = 1 << (ADDR_BITS - 2);

  logic [31:0]          mem [DEPTH];
  logic [31:0]          paddr;
  logic [31:0]          off;
  logic [31:0]          rd_word;
  logic                 in_win;
  logic [ADDR_BITS-3:0] idx;
  logic [31:0]          out_d;
  logic                 out_v;

  // Addresses below the base wrap to huge offsets, so one compare covers both ends.
  always_comb begin
    paddr   = (sram_addr[31:30] == 2'b10) ? {3'b000, sram_addr[28:0]} : sram_addr;
    off     = paddr - BASE_PADDR;
    in_win  = (off >> ADDR_BITS) == 32'd0;
    idx     = off[ADDR_BITS-1:2];
    rd_word = in_win ? mem[idx] : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst && sram_en && in_win) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_wen[i]) mem[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
      end
    end
  end

  // Stages before the output register; the output register itself is the last stage.
  generate
    if (READ_LAT == 1) begin : g_direct
      assign out_d = rd_word;
      assign out_v = sram_en;
    end else begin : g_pipe
      logic [31:0] sh_d [READ_LAT-1];
      logic        sh_v [READ_LAT-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < READ_LAT - 1; i++) begin
            sh_d[i] <= 32'h0;
            sh_v[i] <= 1'b0;
          end
        end else begin
          sh_d[0] <= rd_word;
          sh_v[0] <= sram_en;
          for (int i = 1; i < READ_LAT - 1; i++) begin
            sh_d[i] <= sh_d[i-1];
            sh_v[i] <= sh_v[i-1];
          end
        end
      end

      assign out_d = sh_d[READ_LAT-2];
      assign out_v = sh_v[READ_LAT-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_rdata  <= 32'h0;
      rdata_valid <= 1'b0;
      addr_err    <= 1'b0;
      err_addr    <= 32'h0;
    end else begin
      rdata_valid <= out_v;
      if (out_v) sram_rdata <= out_d;
      if (sram_en && !in_win) begin
        addr_err <= 1'b1;
        if (!addr_err) err_addr <= sram_addr;
      end
    end
  end

`ifdef SRAM_ACCESS_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt  <= 32'h0;
      wr_cnt  <= 32'h0;
      err_cnt <= 16'h0;
    end else if (sram_en) begin
      if (sram_wen == 4'b0000) rd_cnt <= rd_cnt + 32'd1;
      else                     wr_cnt <= wr_cnt + 32'd1;
      if (!in_win && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - scoreboard bench driving READ_LAT=1,2,3 instances with shared stimulus
module tb_sram_responder;

  localparam int NI = 3;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] rdata [NI];
  logic        valid [NI];
  logic        aerr  [NI];
  logic [31:0] eaddr [NI];
`ifdef SRAM_ACCESS_CNT_EN
  logic [31:0] rd_cnt  [NI];
  logic [31:0] wr_cnt  [NI];
  logic [15:0] err_cnt [NI];
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          mon_on = 1'b0;
  exp_t        sb [NI][$];
  logic [31:0] last_rdata [NI];
  logic [31:0] model_mem [int];
  logic        model_err = 1'b0;
  logic [31:0] model_eaddr = 32'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sram_responder #(
      .ADDR_BITS (16),
      .BASE_PADDR(32'h1FC00000),
      .READ_LAT  (g + 1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .sram_en    (sram_en),
      .sram_wen   (sram_wen),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (rdata[g]),
      .rdata_valid(valid[g]),
      .addr_err   (aerr[g]),
      .err_addr   (eaddr[g])
`ifdef SRAM_ACCESS_CNT_EN
      ,
      .rd_cnt     (rd_cnt[g]),
      .wr_cnt     (wr_cnt[g]),
      .err_cnt    (err_cnt[g])
`endif
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request per call: driven just after the falling edge, accepted at the next rising edge.
  task automatic drive(input logic r, input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] pa, off, old, nw;
    logic        win;
    int          w;
    @(negedge clk);
    #1;
    rst = r; sram_en = en; sram_wen = wen; sram_addr = addr; sram_wdata = wdata;
    pa  = (addr[31:30] == 2'b10) ? {3'b000, addr[28:0]} : addr;
    off = pa - 32'h1FC00000;
    win = off < 32'h00010000;
    w   = int'(off[15:2]);
    old = 32'h0;
    if (win) old = model_mem.exists(w) ? model_mem[w] : 32'hxxxxxxxx;
    if (!r && en) begin
      for (int g = 0; g < NI; g++) sb[g].push_back('{old, cyc + g + 1});
    end
    @(posedge clk);
    if (r) begin
      model_err   = 1'b0;
      model_eaddr = 32'h0;
    end else if (en) begin
      if (win) begin
        nw = old;
        for (int i = 0; i < 4; i++) if (wen[i]) nw[8*i +: 8] = wdata[8*i +: 8];
        model_mem[w] = nw;
      end else begin
        if (!model_err) model_eaddr = addr;
        model_err = 1'b1;
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      for (int g = 0; g < NI; g++) begin
        if (rst) begin
          sb[g].delete();
          last_rdata[g] = 32'h0;
        end
        if (valid[g] === 1'b1) begin
          if (sb[g].size() == 0) begin
            check($sformatf("unexpected_valid_l%0d", g + 1), 32'd1, 32'd0);
          end else begin
            e = sb[g].pop_front();
            check($sformatf("rdata_l%0d", g + 1), rdata[g], e.data);
            check($sformatf("latency_l%0d", g + 1), cyc, e.due);
          end
          last_rdata[g] = rdata[g];
        end else begin
          check($sformatf("hold_l%0d", g + 1), rdata[g], last_rdata[g]);
          if (sb[g].size() != 0 && sb[g][0].due < cyc) begin
            check($sformatf("missing_valid_l%0d", g + 1), cyc, sb[g][0].due);
            void'(sb[g].pop_front());
          end
        end
        check($sformatf("addr_err_l%0d", g + 1), aerr[g], model_err);
        check($sformatf("err_addr_l%0d", g + 1), eaddr[g], model_eaddr);
      end
    end
  end

  initial begin
    rst = 1'b1; sram_en = 1'b0; sram_wen = 4'b0; sram_addr = 32'h0; sram_wdata = 32'h0;
    repeat (2) drive(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0);
    #1;
    for (int g = 0; g < NI; g++) begin
      check("reset_rdata", rdata[g], 32'h0);
      check("reset_valid", valid[g], 32'h0);
      check("reset_addr_err", aerr[g], 32'h0);
      check("reset_err_addr", eaddr[g], 32'h0);
    end
    mon_on = 1'b1;

    // Byte-lane merge
    drive(1'b0, 1'b1, 4'b1111, 32'hBFC00010, 32'hDEADBEEF);
    drive(1'b0, 1'b1, 4'b0010, 32'hBFC00010, 32'h00005500);
    drive(1'b0, 1'b1, 4'b0000, 32'hBFC00010, 32'h0);
    #1;
    check("byte_lane_data", rdata[0], 32'hDEAD55EF);
    check("byte_lane_valid", valid[0], 32'h1);

    // Read-before-write
    drive(1'b0, 1'b1, 4'b1111, 32'hBFC00020, 32'h11111111);
    drive(1'b0, 1'b1, 4'b1111, 32'hBFC00020, 32'h22222222);
    #1;
    check("rbw_old", rdata[0], 32'h11111111);
    drive(1'b0, 1'b1, 4'b0000, 32'hBFC00020, 32'h0);
    #1;
    check("rbw_new", rdata[0], 32'h22222222);

    // Back-to-back reads
    drive(1'b0, 1'b1, 4'b1111, 32'hBFC00000, 32'hA0A0A0A0);
    drive(1'b0, 1'b1, 4'b1111, 32'hBFC00004, 32'hB1B1B1B1);
    drive(1'b0, 1'b1, 4'b1111, 32'hBFC00008, 32'hC2C2C2C2);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 4'b0000, 32'hBFC00000 + 32'(4 * i), 32'h0);
    repeat (4) idle();
    #1;
    check("b2b_hold_l3", rdata[2], 32'hC2C2C2C2);
    check("b2b_idle_l3", valid[2], 32'h0);

    // Out-of-window accesses and window edges
    drive(1'b0, 1'b1, 4'b1111, 32'hBFC10000, 32'hFFFFFFFF);
    #1;
    check("oow_data", rdata[0], 32'h0);
    check("oow_valid", valid[0], 32'h1);
    check("oow_addr_err", aerr[0], 32'h1);
    check("oow_err_addr", eaddr[0], 32'hBFC10000);
    drive(1'b0, 1'b1, 4'b0000, 32'h00000000, 32'h0);
    #1;
    check("oow_first_kept", eaddr[0], 32'hBFC10000);
    drive(1'b0, 1'b1, 4'b0000, 32'hBFC00000, 32'h0);
    #1;
    check("oow_no_clobber", rdata[0], 32'hA0A0A0A0);
    drive(1'b0, 1'b1, 4'b1111, 32'hBFC0FFFC, 32'h12345678);
    drive(1'b0, 1'b1, 4'b0000, 32'hBFC0FFFC, 32'h0);
    #1;
    check("last_word", rdata[0], 32'h12345678);
    drive(1'b0, 1'b1, 4'b0000, 32'h1FBFFFFC, 32'h0);
    #1;
    check("below_base", rdata[0], 32'h0);
    drive(1'b0, 1'b1, 4'b0000, 32'h1FC00010, 32'h0);
    #1;
    check("phys_unmapped", rdata[0], 32'hDEAD55EF);
    drive(1'b0, 1'b1, 4'b0000, 32'h9FC00010, 32'h0);
    #1;
    check("kseg0_alias", rdata[0], 32'hDEAD55EF);
    repeat (3) idle();

    // Reset mid-operation; the write presented with reset must be dropped
    drive(1'b0, 1'b1, 4'b0000, 32'hBFC00004, 32'h0);
    drive(1'b1, 1'b1, 4'b1111, 32'hBFC00020, 32'h33333333);
    drive(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0);
    #1;
    for (int g = 0; g < NI; g++) begin
      check("midrst_rdata", rdata[g], 32'h0);
      check("midrst_valid", valid[g], 32'h0);
      check("midrst_addr_err", aerr[g], 32'h0);
    end
    drive(1'b0, 1'b1, 4'b0000, 32'hBFC00020, 32'h0);
    #1;
    check("after_rst_mem", rdata[0], 32'h22222222);

    // Access mix for the counters: 4 reads incl. 1 out-of-window, 2 writes since reset
    drive(1'b0, 1'b1, 4'b1111, 32'hBFC00030, 32'h0BADF00D);
    drive(1'b0, 1'b1, 4'b0011, 32'hBFC00034, 32'h00007777);
    drive(1'b0, 1'b1, 4'b0000, 32'hBFC00030, 32'h0);
    drive(1'b0, 1'b1, 4'b0000, 32'hBFC00004, 32'h0);
    drive(1'b0, 1'b1, 4'b0000, 32'h00001000, 32'h0);
    #1;
`ifdef SRAM_ACCESS_CNT_EN
    for (int g = 0; g < NI; g++) begin
      check("rd_cnt", rd_cnt[g], 32'd4);
      check("wr_cnt", wr_cnt[g], 32'd2);
      check("err_cnt", {16'h0, err_cnt[g]}, 32'd1);
    end
`endif
    check("cnt_mix_oow_addr", eaddr[0], 32'h00001000);

    repeat (6) idle();
    for (int g = 0; g < NI; g++) check("sb_drain", sb[g].size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
